// File: rtl/worker_pool_arbiter_if.sv
// Shared width defaults and the arbiter handshake bundle.
// master is the arbiter view, slave is the upstream/worker/sink view.
package worker_pool_pkg;
  localparam int PACKET_WIDTH        = 32;
  localparam int WORKER_RESULT_WIDTH = 32;
endpackage

interface worker_pool_arbiter_if
  import worker_pool_pkg::*;
#(
  parameter int PW  = PACKET_WIDTH,
  parameter int WRW = WORKER_RESULT_WIDTH,
  parameter int NW  = 4
);
  logic              RECEIVE_PC_VALID;
  logic [PW-1:0]     RECEIVE_PC_DATA;
  logic              RECEIVE_PC_READY;
  logic [NW-1:0]     SEND_PC_VALID;
  logic [PW-1:0]     SEND_PC_DATA;
  logic [NW-1:0]     SEND_PC_READY;
  logic [NW-1:0]     RECEIVE_WR_VALID;
  logic [NW*WRW-1:0] RECEIVE_WR_DATA;
  logic [NW-1:0]     RECEIVE_WR_READY;
  logic              SEND_WR_VALID;
  logic [WRW-1:0]    SEND_WR_DATA;
  logic              SEND_WR_READY;

  modport master (
    input  RECEIVE_PC_VALID, RECEIVE_PC_DATA,
    output RECEIVE_PC_READY,
    output SEND_PC_VALID, SEND_PC_DATA,
    input  SEND_PC_READY,
    input  RECEIVE_WR_VALID, RECEIVE_WR_DATA,
    output RECEIVE_WR_READY,
    output SEND_WR_VALID, SEND_WR_DATA,
    input  SEND_WR_READY
  );

  modport slave (
    output RECEIVE_PC_VALID, RECEIVE_PC_DATA,
    input  RECEIVE_PC_READY,
    input  SEND_PC_VALID, SEND_PC_DATA,
    output SEND_PC_READY,
    output RECEIVE_WR_VALID, RECEIVE_WR_DATA,
    input  RECEIVE_WR_READY,
    input  SEND_WR_VALID, SEND_WR_DATA,
    output SEND_WR_READY
  );
endinterface

// File: rtl/worker_pool_arbiter.sv
// Round-robin packet dispatch to a worker pool plus
// round-robin merge of worker results into one stream.
module worker_pool_arbiter
  import worker_pool_pkg::*;
#(
  parameter int PACKET_WIDTH        = worker_pool_pkg::PACKET_WIDTH,
  parameter int WORKER_RESULT_WIDTH = worker_pool_pkg::WORKER_RESULT_WIDTH,
  parameter int NUM_WORKERS         = 4
) (
  input logic               CLK,
  input logic               RST,
  worker_pool_arbiter_if.master bus
);
  localparam int IW  = $clog2(NUM_WORKERS);
  localparam int WRW = WORKER_RESULT_WIDTH;
  localparam logic [NUM_WORKERS-1:0] ONE = NUM_WORKERS'(1);

  typedef enum logic {D_RECEIVE, D_SEND} d_state_t;
  typedef enum logic {R_RECEIVE, R_SEND} r_state_t;

  d_state_t                d_state;
  logic [IW-1:0]           dptr, d_sel, d_pick, d_next;
  logic                    d_hit;
  logic                    pc_ready;
  logic [NUM_WORKERS-1:0]  pc_valid;
  logic [PACKET_WIDTH-1:0] pc_data;

  r_state_t                r_state;
  logic [IW-1:0]           rptr, r_sel, r_pick, r_next;
  logic                    r_hit;
  logic [NUM_WORKERS-1:0]  wr_ready;
  logic                    wr_valid;
  logic [WRW-1:0]          wr_data;

  assign bus.RECEIVE_PC_READY = pc_ready;
  assign bus.SEND_PC_VALID    = pc_valid;
  assign bus.SEND_PC_DATA     = pc_data;
  assign bus.RECEIVE_WR_READY = wr_ready;
  assign bus.SEND_WR_VALID    = wr_valid;
  assign bus.SEND_WR_DATA     = wr_data;

  // Scan downward so the lowest offset from the pointer wins.
  always_comb begin : scan
    int di;
    int ri;
    d_hit  = 1'b0;
    d_pick = '0;
    r_hit  = 1'b0;
    r_pick = '0;
    for (int k = NUM_WORKERS - 1; k >= 0; k--) begin
      di = (int'(dptr) + k) % NUM_WORKERS;
      ri = (int'(rptr) + k) % NUM_WORKERS;
      if (bus.SEND_PC_READY[di]) begin
        d_hit  = 1'b1;
        d_pick = IW'(di);
      end
      if (bus.RECEIVE_WR_VALID[ri]) begin
        r_hit  = 1'b1;
        r_pick = IW'(ri);
      end
    end
    d_next = IW'((int'(d_sel) + 1) % NUM_WORKERS);
    r_next = IW'((int'(r_sel) + 1) % NUM_WORKERS);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      d_state  <= D_RECEIVE;
      dptr     <= '0;
      d_sel    <= '0;
      pc_ready <= 1'b0;
      pc_valid <= '0;
      pc_data  <= '0;
    end else begin
      unique case (d_state)
        D_RECEIVE: begin
          if (pc_ready && bus.RECEIVE_PC_VALID) begin
            pc_data  <= bus.RECEIVE_PC_DATA;
            pc_ready <= 1'b0;
            d_state  <= D_SEND;
          end else begin
            pc_ready <= 1'b1;
          end
        end
        D_SEND: begin
          if (pc_valid == '0) begin
            if (d_hit) begin
              pc_valid <= ONE << d_pick;
              d_sel    <= d_pick;
            end
          end else if (bus.SEND_PC_READY[d_sel]) begin
            pc_valid <= '0;
            dptr     <= d_next;
            pc_ready <= 1'b1;
            d_state  <= D_RECEIVE;
          end
        end
        default: d_state <= D_RECEIVE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= R_RECEIVE;
      rptr     <= '0;
      r_sel    <= '0;
      wr_ready <= '0;
      wr_valid <= 1'b0;
      wr_data  <= '0;
    end else begin
      unique case (r_state)
        R_RECEIVE: begin
          if (wr_ready == '0) begin
            if (r_hit) begin
              wr_ready <= ONE << r_pick;
              r_sel    <= r_pick;
            end
          end else if (bus.RECEIVE_WR_VALID[r_sel]) begin
            wr_data  <= bus.RECEIVE_WR_DATA[r_sel*WRW +: WRW];
            wr_ready <= '0;
            wr_valid <= 1'b1;
            rptr     <= r_next;
            r_state  <= R_SEND;
          end else begin
            // Worker withdrew its result: drop the grant and re-arbitrate.
            wr_ready <= '0;
          end
        end
        R_SEND: begin
          if (bus.SEND_WR_READY) begin
            wr_valid <= 1'b0;
            r_state  <= R_RECEIVE;
          end
        end
        default: r_state <= R_RECEIVE;
      endcase
    end
  end
endmodule
